dpram_lat_ctrl: RTL and testbench

Parametrised true dual-port RAM with an independent, compile-time write latency and read latency on each port. This is the next generation of the team's latency-configurable dual-port memory. It adds byte-enabled writes, same-address write-collision detection and arbitration, per-port in-flight tracking and an idle indication. It sits between the test/DUT traffic generators and the storage array, and is the memory model used by the latency benches.

---
 rtl/dpram_lat_ctrl_pkg.sv | 38 +++
 rtl/dpram_lat_ctrl_if.sv | 41 ++++
 rtl/dpram_lat_ctrl_pipe.sv | 40 ++++
 rtl/dpram_lat_ctrl.sv | 101 ++++++++++
 tb/tb_dpram_lat_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_lat_ctrl_pkg.sv
// Shared configuration, pipeline entry types and address helper for the
// latency-configurable dual-port RAM.
package pkg_dpram;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned MEM_DEPTH   = 16;
  localparam int unsigned ADDR_WIDTH  = $clog2(MEM_DEPTH);
  localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8;
  localparam int unsigned WR_LATENCYA = 10;
  localparam int unsigned RD_LATENCYA = 5;
  localparam int unsigned WR_LATENCYB = 7;
  localparam int unsigned RD_LATENCYB = 8;
  localparam int unsigned PENDA_WIDTH = $clog2(WR_LATENCYA + 1);
  localparam int unsigned PENDB_WIDTH = $clog2(WR_LATENCYB + 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [BE_WIDTH-1:0]   be_t;

  // valid is the MSB of both entries; the generic pipe relies on that
  typedef struct packed {
    logic  valid;
    addr_t addr;
    be_t   be;
    data_t data;
  } wr_entry_t;

  typedef struct packed {
    logic  valid;
    logic  addr_ok;
    data_t data;
  } rd_entry_t;

  function automatic logic addr_in_range(addr_t a);
    return 32'(a) < MEM_DEPTH;
  endfunction

endpackage

// File: rtl/dpram_lat_ctrl_if.sv
// Request/response bundle for both RAM ports plus status outputs.
interface dpram_lat_ctrl_if;
  import pkg_dpram::*;

  logic                   a_en;
  logic                   a_we;
  be_t                    a_be;
  addr_t                  a_addr;
  data_t                  a_wdata;
  data_t                  a_rdata;
  logic                   a_rvalid;

  logic                   b_en;
  logic                   b_we;
  be_t                    b_be;
  addr_t                  b_addr;
  data_t                  b_wdata;
  data_t                  b_rdata;
  logic                   b_rvalid;

  logic [PENDA_WIDTH-1:0] a_wr_pending;
  logic [PENDB_WIDTH-1:0] b_wr_pending;
  logic                   wr_collision;
  addr_t                  collision_addr;
  logic                   idle;

  modport master (
    output a_en, a_we, a_be, a_addr, a_wdata,
    output b_en, b_we, b_be, b_addr, b_wdata,
    input  a_rdata, a_rvalid, b_rdata, b_rvalid,
    input  a_wr_pending, b_wr_pending, wr_collision, collision_addr, idle
  );

  modport slave (
    input  a_en, a_we, a_be, a_addr, a_wdata,
    input  b_en, b_we, b_be, b_addr, b_wdata,
    output a_rdata, a_rvalid, b_rdata, b_rvalid,
    output a_wr_pending, b_wr_pending, wr_collision, collision_addr, idle
  );

endinterface

// File: rtl/dpram_lat_ctrl_pipe.sv
// Generic delay line of DEPTH stages for an entry whose MSB is its valid bit;
// DEPTH=0 is a pass-through. rst flushes every stage.
module dpram_lat_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  T     in_i,
  output T     out_c,
  output logic occ_next_c
);

  localparam int unsigned W = $bits(T);

  if (DEPTH == 0) begin : g_pass
    assign out_c      = in_i;
    assign occ_next_c = 1'b0;
  end else begin : g_shift
    logic [W-1:0] stg_q [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stg_q[i] <= '0;
      end else begin
        stg_q[0] <= in_i;
        for (int unsigned i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
      end
    end

    assign out_c = T'(stg_q[DEPTH-1]);

    // Occupancy the stages will have after the coming edge
    always_comb begin
      occ_next_c = in_i[W-1];
      for (int unsigned i = 0; i + 1 < DEPTH; i++) occ_next_c = occ_next_c | stg_q[i][W-1];
    end
  end

endmodule

// File: rtl/dpram_lat_ctrl.sv
// True dual-port RAM with per-port write/read latency, byte enables,
// same-address write arbitration (A wins), in-flight counters and idle.
module dpram_lat_ctrl
  import pkg_dpram::*;
(
  input logic             clk,
  input logic             rst,
  dpram_lat_ctrl_if.slave bus
);

  data_t                  mem_q [MEM_DEPTH];
  wr_entry_t              a_wr_in, a_wr_out, b_wr_in, b_wr_out;
  rd_entry_t              a_rd_in, a_rd_out, b_rd_in, b_rd_out;
  logic                   a_wr_occ, b_wr_occ, a_rd_occ, b_rd_occ;
  logic                   a_cmt_ok, b_cmt_ok, coll;
  data_t                  a_rdata_q, b_rdata_q;
  logic                   a_rvalid_q, b_rvalid_q, wr_collision_q, idle_q;
  addr_t                  collision_addr_q;
  logic [PENDA_WIDTH-1:0] a_pend_q, a_pend_d;
  logic [PENDB_WIDTH-1:0] b_pend_q, b_pend_d;

  // Reads sample the array before this cycle's commit, giving old data
  always_comb begin
    a_wr_in         = '{valid: bus.a_en & bus.a_we, addr: bus.a_addr, be: bus.a_be, data: bus.a_wdata};
    b_wr_in         = '{valid: bus.b_en & bus.b_we, addr: bus.b_addr, be: bus.b_be, data: bus.b_wdata};
    a_rd_in.valid   = bus.a_en & ~bus.a_we;
    a_rd_in.addr_ok = addr_in_range(bus.a_addr);
    a_rd_in.data    = a_rd_in.addr_ok ? mem_q[bus.a_addr] : '0;
    b_rd_in.valid   = bus.b_en & ~bus.b_we;
    b_rd_in.addr_ok = addr_in_range(bus.b_addr);
    b_rd_in.data    = b_rd_in.addr_ok ? mem_q[bus.b_addr] : '0;
  end

  dpram_lat_pipe #(.DEPTH(WR_LATENCYA - 1), .T(wr_entry_t)) u_a_wr (
    .clk(clk), .rst(rst), .in_i(a_wr_in), .out_c(a_wr_out), .occ_next_c(a_wr_occ));
  dpram_lat_pipe #(.DEPTH(WR_LATENCYB - 1), .T(wr_entry_t)) u_b_wr (
    .clk(clk), .rst(rst), .in_i(b_wr_in), .out_c(b_wr_out), .occ_next_c(b_wr_occ));
  dpram_lat_pipe #(.DEPTH(RD_LATENCYA - 1), .T(rd_entry_t)) u_a_rd (
    .clk(clk), .rst(rst), .in_i(a_rd_in), .out_c(a_rd_out), .occ_next_c(a_rd_occ));
  dpram_lat_pipe #(.DEPTH(RD_LATENCYB - 1), .T(rd_entry_t)) u_b_rd (
    .clk(clk), .rst(rst), .in_i(b_rd_in), .out_c(b_rd_out), .occ_next_c(b_rd_occ));

  always_comb begin
    a_cmt_ok = a_wr_out.valid & ~rst & addr_in_range(a_wr_out.addr);
    b_cmt_ok = b_wr_out.valid & ~rst & addr_in_range(b_wr_out.addr);
    coll     = a_cmt_ok & b_cmt_ok & (a_wr_out.addr == b_wr_out.addr);
    a_pend_d = a_pend_q + PENDA_WIDTH'(a_wr_in.valid) - PENDA_WIDTH'(a_wr_out.valid);
    b_pend_d = b_pend_q + PENDB_WIDTH'(b_wr_in.valid) - PENDB_WIDTH'(b_wr_out.valid);
  end

  // Array commit: on a same-address collision port B only fills bytes A leaves alone
  always_ff @(posedge clk) begin
    if (b_cmt_ok) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (b_wr_out.be[i] && !(coll && a_wr_out.be[i]))
          mem_q[b_wr_out.addr][8*i +: 8] <= b_wr_out.data[8*i +: 8];
      end
    end
    if (a_cmt_ok) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (a_wr_out.be[i]) mem_q[a_wr_out.addr][8*i +: 8] <= a_wr_out.data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q        <= '0;
      b_rdata_q        <= '0;
      a_rvalid_q       <= 1'b0;
      b_rvalid_q       <= 1'b0;
      wr_collision_q   <= 1'b0;
      collision_addr_q <= '0;
      a_pend_q         <= '0;
      b_pend_q         <= '0;
      idle_q           <= 1'b1;
    end else begin
      a_rvalid_q     <= a_rd_out.valid;
      b_rvalid_q     <= b_rd_out.valid;
      if (a_rd_out.valid) a_rdata_q <= a_rd_out.addr_ok ? a_rd_out.data : '0;
      if (b_rd_out.valid) b_rdata_q <= b_rd_out.addr_ok ? b_rd_out.data : '0;
      wr_collision_q <= coll;
      if (coll) collision_addr_q <= a_wr_out.addr;
      a_pend_q       <= a_pend_d;
      b_pend_q       <= b_pend_d;
      idle_q         <= ~(a_wr_occ | b_wr_occ | a_rd_occ | b_rd_occ |
                          a_rd_out.valid | b_rd_out.valid);
    end
  end

  assign bus.a_rdata        = a_rdata_q;
  assign bus.b_rdata        = b_rdata_q;
  assign bus.a_rvalid       = a_rvalid_q;
  assign bus.b_rvalid       = b_rvalid_q;
  assign bus.wr_collision   = wr_collision_q;
  assign bus.collision_addr = collision_addr_q;
  assign bus.a_wr_pending   = a_pend_q;
  assign bus.b_wr_pending   = b_pend_q;
  assign bus.idle           = idle_q;

endmodule

// File: tb/tb_dpram_lat_ctrl.sv
// Bench for dpram_lat_ctrl: issue-time model with due-cycle queues checked
// every cycle, plus literal checkpoints for the key scenarios.
module tb_dpram_lat_ctrl;
  import pkg_dpram::*;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  bit   started;

  dpram_lat_ctrl_if bus();
  dpram_lat_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          port_b;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wop_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rop_t;

  logic [31:0] mem_m [16];
  wop_t        wq[$];
  rop_t        rqa[$];
  rop_t        rqb[$];
  logic [31:0] exp_a_rdata, exp_b_rdata;
  logic        exp_a_rvalid, exp_b_rvalid, exp_coll, exp_idle;
  logic [3:0]  exp_caddr;
  int          exp_a_pend, exp_b_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Model: each op is resolved by its issue cycle plus the port latency
  always @(negedge clk) begin : model
    wop_t ca, cb;
    wop_t keep[$];
    bit   ha, hb, coll;
    if (started) begin
      chk("a_rvalid", 32'(bus.a_rvalid), 32'(exp_a_rvalid));
      chk("b_rvalid", 32'(bus.b_rvalid), 32'(exp_b_rvalid));
      chk("a_rdata", bus.a_rdata, exp_a_rdata);
      chk("b_rdata", bus.b_rdata, exp_b_rdata);
      chk("a_wr_pending", 32'(bus.a_wr_pending), 32'(exp_a_pend));
      chk("b_wr_pending", 32'(bus.b_wr_pending), 32'(exp_b_pend));
      chk("wr_collision", 32'(bus.wr_collision), 32'(exp_coll));
      chk("collision_addr", 32'(bus.collision_addr), 32'(exp_caddr));
      chk("idle", 32'(bus.idle), 32'(exp_idle));
    end
    if (rst) begin
      wq.delete();
      rqa.delete();
      rqb.delete();
      exp_a_rdata = '0; exp_b_rdata = '0;
      exp_a_rvalid = 1'b0; exp_b_rvalid = 1'b0;
      exp_coll = 1'b0; exp_caddr = '0; exp_idle = 1'b1;
      exp_a_pend = 0; exp_b_pend = 0;
      started = 1'b1;
    end else begin
      if (bus.a_en && !bus.a_we) rqa.push_back('{cyc + RD_LATENCYA, mem_m[bus.a_addr]});
      if (bus.b_en && !bus.b_we) rqb.push_back('{cyc + RD_LATENCYB, mem_m[bus.b_addr]});
      if (bus.a_en && bus.a_we)
        wq.push_back('{cyc + WR_LATENCYA - 1, 1'b0, bus.a_addr, bus.a_be, bus.a_wdata});
      if (bus.b_en && bus.b_we)
        wq.push_back('{cyc + WR_LATENCYB - 1, 1'b1, bus.b_addr, bus.b_be, bus.b_wdata});
      ha = 1'b0; hb = 1'b0;
      keep.delete();
      foreach (wq[i]) begin
        if (wq[i].due == cyc) begin
          if (wq[i].port_b) begin cb = wq[i]; hb = 1'b1; end
          else              begin ca = wq[i]; ha = 1'b1; end
        end else keep.push_back(wq[i]);
      end
      wq = keep;
      coll = ha && hb && (ca.addr == cb.addr);
      for (int i = 0; i < 4; i++) begin
        if (hb && cb.be[i] && !(coll && ca.be[i])) mem_m[cb.addr][8*i +: 8] = cb.data[8*i +: 8];
        if (ha && ca.be[i]) mem_m[ca.addr][8*i +: 8] = ca.data[8*i +: 8];
      end
      exp_coll = coll;
      if (coll) exp_caddr = ca.addr;
      exp_idle = (wq.size() == 0) && (rqa.size() == 0) && (rqb.size() == 0);
      exp_a_pend = 0; exp_b_pend = 0;
      foreach (wq[i]) begin
        if (wq[i].port_b) exp_b_pend++;
        else              exp_a_pend++;
      end
      exp_a_rvalid = (rqa.size() > 0) && (rqa[0].due == cyc + 1);
      if (exp_a_rvalid) begin exp_a_rdata = rqa[0].data; void'(rqa.pop_front()); end
      exp_b_rvalid = (rqb.size() > 0) && (rqb[0].due == cyc + 1);
      if (exp_b_rvalid) begin exp_b_rdata = rqb[0].data; void'(rqb.pop_front()); end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
    bus.a_en = 1'b0;
    bus.b_en = 1'b0;
  endtask

  task automatic a_op(input bit we, input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
    bus.a_en = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d; bus.a_be = be;
  endtask

  task automatic b_op(input bit we, input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
    bus.b_en = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d; bus.b_be = be;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    next();
    while (!bus.idle && n < 200) begin next(); n++; end
    chk("idle_timeout", 32'(bus.idle), 32'd1);
  endtask

  task automatic read_check_a(input logic [3:0] addr, input logic [31:0] exp, input string nm);
    a_op(1'b0, addr, '0, '0);
    repeat (RD_LATENCYA) next();
    chk({nm, "_rvalid"}, 32'(bus.a_rvalid), 32'd1);
    chk(nm, bus.a_rdata, exp);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    total = 0; bad = 0; started = 1'b0;
    rst = 1'b1;
    bus.a_en = 0; bus.a_we = 0; bus.a_be = '0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_en = 0; bus.b_we = 0; bus.b_be = '0; bus.b_addr = '0; bus.b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_idle", 32'(bus.idle), 32'd1);
    chk("reset_pending", 32'(bus.a_wr_pending), 32'd0);

    // Preload every word through port A, one per cycle
    for (int i = 0; i < 16; i++) begin
      a_op(1'b1, 4'(i), 32'hC0DE_0000 | 32'(i), 4'hF);
      next();
    end
    wait_idle();

    // Back-to-back reads 0..15 on port A
    for (int r = 0; r <= 21; r++) begin
      if (r <= 15) a_op(1'b0, 4'(r), '0, '0);
      if (r >= 5 && r <= 20) begin
        chk("burst_rvalid", 32'(bus.a_rvalid), 32'd1);
        chk("burst_rdata", bus.a_rdata, 32'hC0DE_0000 | 32'(r - 5));
      end
      if (r >= 1 && r <= 20) chk("burst_busy", 32'(bus.idle), 32'd0);
      if (r == 21) chk("burst_idle_after", 32'(bus.idle), 32'd1);
      if (r < 21) next();
    end
    wait_idle();

    // Write latency A vs cross-port read latency B
    for (int r = 0; r <= 20; r++) begin
      if (r == 0) a_op(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
      if (r == 10) b_op(1'b0, 4'd3, '0, '0);
      if (r >= 1) begin
        chk("t1_a_pending", 32'(bus.a_wr_pending), (r <= 9) ? 32'd1 : 32'd0);
        chk("t1_b_rvalid", 32'(bus.b_rvalid), (r == 18) ? 32'd1 : 32'd0);
      end
      if (r == 18) chk("t1_b_rdata", bus.b_rdata, 32'hDEAD_BEEF);
      next();
    end
    wait_idle();

    // Byte-enabled write on port B
    a_op(1'b1, 4'd5, 32'h1122_3344, 4'hF);
    wait_idle();
    b_op(1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101);
    wait_idle();
    read_check_a(4'd5, 32'h11BB_33DD, "t2_merge");
    wait_idle();

    // Same-address collisions: full A enables, then partial
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r <= 12; r++) begin
        if (r == 0) a_op(1'b1, 4'd7, 32'hAAAA_AAAA, (k == 0) ? 4'hF : 4'b0011);
        if (r == 3) b_op(1'b1, 4'd7, 32'h5555_5555, 4'hF);
        if (r >= 1) chk("t3_collision", 32'(bus.wr_collision), (r == 10) ? 32'd1 : 32'd0);
        if (r == 10) chk("t3_coll_addr", 32'(bus.collision_addr), 32'd7);
        next();
      end
      wait_idle();
      read_check_a(4'd7, (k == 0) ? 32'hAAAA_AAAA : 32'h5555_AAAA, "t3_mem");
      wait_idle();
    end

    // Read-during-write across ports returns old data, next cycle new
    a_op(1'b1, 4'd9, 32'h1, 4'hF);
    wait_idle();
    for (int r = 0; r <= 13; r++) begin
      if (r == 0) b_op(1'b1, 4'd9, 32'h2, 4'hF);
      if (r == 6 || r == 7) a_op(1'b0, 4'd9, '0, '0);
      if (r == 11) chk("t6_old", bus.a_rdata, 32'h1);
      if (r == 12) chk("t6_new", bus.a_rdata, 32'h2);
      next();
    end
    wait_idle();

    // Reset while a write and a read are in flight
    for (int r = 0; r <= 12; r++) begin
      if (r == 0) a_op(1'b1, 4'd2, 32'hBADB_AD00, 4'hF);
      if (r == 2) a_op(1'b0, 4'd2, '0, '0);
      if (r == 4) rst = 1'b1;
      if (r == 5) begin
        rst = 1'b0;
        chk("t5_pending", 32'(bus.a_wr_pending), 32'd0);
        chk("t5_idle", 32'(bus.idle), 32'd1);
      end
      if (r >= 5) chk("t5_no_rvalid", 32'(bus.a_rvalid), 32'd0);
      next();
    end
    read_check_a(4'd2, 32'hC0DE_0002, "t5_unchanged");
    wait_idle();

    // Mixed traffic on both ports every cycle
    for (int i = 0; i < 40; i++) begin
      a_op((i % 3) == 0, 4'((i * 5) % 16), 32'h0100_0000 * 32'(i) ^ 32'h00A5_5A0F, 4'((i * 3) % 16));
      if ((i % 4) != 3) b_op((i % 2) == 0, 4'((i * 3 + 1) % 16), 32'h3C00_0000 + 32'(i * 17), 4'(i + 1));
      next();
    end
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      a_op(1'b0, 4'(i), '0, '0);
      b_op(1'b0, 4'(15 - i), '0, '0);
      next();
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
